// File: rtl/commit_retire_unit.sv
// Commit/retire stage: consumes the ROB commit bus, drives register-file writes, an in-order store FIFO,
// predictor/BTB updates and mispredict recovery. Optional statistics counters under COMMIT_STATS_EN.
package commit_retire_pkg;
    typedef struct packed {
        logic        validCommit;
        logic [31:0] result;
        logic [31:0] destCommit;
        logic [3:0]  commitInfo;     // {regWrite, memWrite, jump, branch}
        logic [7:0]  controlFlow;    // {isControl, state[1:0], writeBTB, takenBranch, mispredict, misdirect, reset}
        logic [31:0] targetAddress;
        logic [31:0] oldPC;
        logic [31:0] statusSnap;
        logic [7:0]  previousIndex;
    } commit_bus_t;
endpackage

module commit_retire_unit #(
    parameter int WIDTH     = 31,
    parameter int CONTROL   = 7,
    parameter int INDEX     = 7,
    parameter int SQ_DEPTH  = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  commit_retire_pkg::commit_bus_t commitBus,
    output logic                          rfWrite,
    output logic [4:0]                    rfDest,
    output logic [WIDTH:0]                rfData,
    output logic                          memReq,
    output logic [WIDTH:0]                memAddr,
    output logic [WIDTH:0]                memData,
    input  logic                          memAck,
    output logic                          redirect,
    output logic [WIDTH:0]                redirectPC,
    output logic                          flush,
    output logic                          statusRestore,
    output logic [WIDTH:0]                statusSnapOut,
    output logic                          phtUpdate,
    output logic [INDEX:0]                phtIndex,
    output logic [1:0]                    phtState,
    output logic                          btbWrite,
    output logic [WIDTH:0]                btbPC,
    output logic [WIDTH:0]                btbTarget,
    output logic                          freeze
`ifdef COMMIT_STATS_EN
    ,
    output logic [31:0]                   retiredCount,
    output logic [31:0]                   flushCount,
    output logic [31:0]                   stallCycles
`endif
);
    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH:0] sq_addr_q [SQ_DEPTH];
    logic [WIDTH:0] sq_data_q [SQ_DEPTH];

    logic rf_write_q, rf_write_d, redirect_q, redirect_d, restore_q, restore_d;
    logic pht_update_q, pht_update_d, btb_write_q, btb_write_d;
    logic [4:0] rf_dest_q, rf_dest_d;
    logic [INDEX:0] pht_index_q, pht_index_d;
    logic [1:0] pht_state_q, pht_state_d;
    logic [WIDTH:0] rf_data_q, rf_data_d, redirect_pc_q, redirect_pc_d, snap_q, snap_d;
    logic [WIDTH:0] btb_pc_q, btb_pc_d, btb_target_q, btb_target_d;

    logic accept, is_control, detect, reg_write, mem_write, branch;
    logic push, pop, full, empty, drop;
    logic unused_ok;

    assign unused_ok  = ^{commitBus.controlFlow[0], commitBus.commitInfo[1]};
    assign reg_write  = commitBus.commitInfo[3];
    assign mem_write  = commitBus.commitInfo[2];
    assign branch     = commitBus.commitInfo[0];
    assign is_control = commitBus.controlFlow[CONTROL];
    // Wrong-path commits arriving while the pipeline is being flushed are discarded.
    assign accept     = commitBus.validCommit & (state_q == ST_IDLE);
    assign detect     = accept & is_control & (commitBus.controlFlow[CONTROL-5] | commitBus.controlFlow[CONTROL-6]);

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(SQ_DEPTH));
    assign pop   = memAck & ~empty;
    assign push  = accept & mem_write & (~full | pop);
    assign drop  = accept & mem_write & full & ~pop;

    always_comb begin
        rf_write_d    = accept & reg_write & (commitBus.destCommit[4:0] != 5'd0);
        rf_dest_d     = rf_dest_q;
        rf_data_d     = rf_data_q;
        pht_update_d  = accept & is_control & branch;
        btb_write_d   = accept & is_control & commitBus.controlFlow[CONTROL-3];
        pht_index_d   = pht_index_q;
        pht_state_d   = pht_state_q;
        btb_pc_d      = btb_pc_q;
        btb_target_d  = btb_target_q;
        redirect_d    = detect;
        restore_d     = detect;
        redirect_pc_d = redirect_pc_q;
        snap_d        = snap_q;
        if (accept) begin
            rf_dest_d = commitBus.destCommit[4:0];
            rf_data_d = commitBus.result;
        end
        if (accept & is_control) begin
            pht_index_d  = commitBus.previousIndex[INDEX:0];
            pht_state_d  = commitBus.controlFlow[CONTROL-1:CONTROL-2];
            btb_pc_d     = commitBus.oldPC;
            btb_target_d = commitBus.targetAddress;
        end
        if (detect) begin
            redirect_pc_d = commitBus.controlFlow[CONTROL-4] ? commitBus.targetAddress
                                                             : commitBus.oldPC + (WIDTH+1)'(4);
            snap_d        = commitBus.statusSnap;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYC - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) state_d = ST_IDLE;
                else flush_cnt_d = flush_cnt_q - FW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;       flush_cnt_q <= '0;
            wr_ptr_q <= '0;           rd_ptr_q <= '0;         count_q <= '0;
            rf_write_q <= 1'b0;       rf_dest_q <= '0;        rf_data_q <= '0;
            redirect_q <= 1'b0;       restore_q <= 1'b0;      redirect_pc_q <= '0;  snap_q <= '0;
            pht_update_q <= 1'b0;     pht_index_q <= '0;      pht_state_q <= '0;
            btb_write_q <= 1'b0;      btb_pc_q <= '0;         btb_target_q <= '0;
        end else begin
            state_q <= state_d;       flush_cnt_q <= flush_cnt_d;
            wr_ptr_q <= wr_ptr_d;     rd_ptr_q <= rd_ptr_d;   count_q <= count_d;
            rf_write_q <= rf_write_d; rf_dest_q <= rf_dest_d; rf_data_q <= rf_data_d;
            redirect_q <= redirect_d; restore_q <= restore_d; redirect_pc_q <= redirect_pc_d; snap_q <= snap_d;
            pht_update_q <= pht_update_d; pht_index_q <= pht_index_d; pht_state_q <= pht_state_d;
            btb_write_q <= btb_write_d;   btb_pc_q <= btb_pc_d;   btb_target_q <= btb_target_d;
        end
    end

    // Store payload needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            sq_addr_q[wr_ptr_q] <= commitBus.destCommit;
            sq_data_q[wr_ptr_q] <= commitBus.result;
        end
    end

    assign rfWrite       = rf_write_q;
    assign rfDest        = rf_dest_q;
    assign rfData        = rf_data_q;
    assign memReq        = ~empty;
    assign memAddr       = empty ? '0 : sq_addr_q[rd_ptr_q];
    assign memData       = empty ? '0 : sq_data_q[rd_ptr_q];
    assign redirect      = redirect_q;
    assign redirectPC    = redirect_pc_q;
    assign flush         = (state_q == ST_FLUSH);
    assign statusRestore = restore_q;
    assign statusSnapOut = snap_q;
    assign phtUpdate     = pht_update_q;
    assign phtIndex      = pht_index_q;
    assign phtState      = pht_state_q;
    assign btbWrite      = btb_write_q;
    assign btbPC         = btb_pc_q;
    assign btbTarget     = btb_target_q;
    // One free slot is kept so the commit already in flight when freeze rises can still enqueue.
    assign freeze        = (state_q == ST_FLUSH) | (count_q >= CW'(SQ_DEPTH - 1));

`ifdef COMMIT_STATS_EN
    logic [31:0] retired_q, retired_d, flushes_q, flushes_d, stalls_q, stalls_d;

    always_comb begin
        retired_d = retired_q + {31'd0, accept};
        flushes_d = flushes_q + {31'd0, detect};
        stalls_d  = stalls_q + {31'd0, freeze};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            retired_q <= '0; flushes_q <= '0; stalls_q <= '0;
        end else begin
            retired_q <= retired_d; flushes_q <= flushes_d; stalls_q <= stalls_d;
        end
    end

    assign retiredCount = retired_q;
    assign flushCount   = flushes_q;
    assign stallCycles  = stalls_q;
`endif

`ifndef SYNTHESIS
    store_not_dropped: assert property (@(posedge clk) disable iff (!resetN) !drop);
`endif
endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed bench for commit_retire_unit: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_commit_retire_unit;
    localparam int SQ = 4;
    localparam int FC = 2;
    localparam logic [3:0] CI_RW = 4'h8, CI_MW = 4'h4, CI_BR = 4'h1;
    localparam logic [7:0] CF_CTRL = 8'h80, CF_BTB = 8'h10, CF_TAKEN = 8'h08, CF_MISP = 8'h04, CF_MISD = 8'h02;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic memAck = 1'b0;
    commit_retire_pkg::commit_bus_t bus = '0;
    logic rfWrite, memReq, redirect, flush, statusRestore, phtUpdate, btbWrite, freeze;
    logic [4:0] rfDest;
    logic [7:0] phtIndex;
    logic [1:0] phtState;
    logic [31:0] rfData, memAddr, memData, redirectPC, statusSnapOut, btbPC, btbTarget;
`ifdef COMMIT_STATS_EN
    logic [31:0] retiredCount, flushCount, stallCycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    commit_retire_unit dut (
        .clk(clk), .resetN(resetN), .commitBus(bus),
        .rfWrite(rfWrite), .rfDest(rfDest), .rfData(rfData),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memAck(memAck),
        .redirect(redirect), .redirectPC(redirectPC), .flush(flush),
        .statusRestore(statusRestore), .statusSnapOut(statusSnapOut),
        .phtUpdate(phtUpdate), .phtIndex(phtIndex), .phtState(phtState),
        .btbWrite(btbWrite), .btbPC(btbPC), .btbTarget(btbTarget), .freeze(freeze)
`ifdef COMMIT_STATS_EN
        , .retiredCount(retiredCount), .flushCount(flushCount), .stallCycles(stallCycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the cycle after each rising edge.
    logic e_rfw = 0, e_redir = 0, e_pht = 0, e_btb = 0, e_flush = 0, e_freeze = 0;
    logic [31:0] e_rfdest = 0, e_rfdata = 0, e_rpc = 0, e_snap = 0, e_pidx = 0, e_pst = 0, e_bpc = 0, e_btgt = 0;
    logic [31:0] q_addr[$], q_data[$];
    int flush_left = 0;
    logic [31:0] m_ret = 0, m_fl = 0, m_stall = 0;

    always @(posedge clk or negedge resetN) begin : model
        logic acc, det;
        if (!resetN) begin
            e_rfw = 0; e_redir = 0; e_pht = 0; e_btb = 0; e_flush = 0; e_freeze = 0;
            q_addr.delete(); q_data.delete();
            flush_left = 0; m_ret = 0; m_fl = 0; m_stall = 0;
        end else begin
            if (e_freeze) m_stall++;
            acc = bus.validCommit && (flush_left == 0);
            det = acc && bus.controlFlow[7] && (bus.controlFlow[2] || bus.controlFlow[1]);
            e_rfw = acc && bus.commitInfo[3] && (bus.destCommit % 32 != 0);
            e_rfdest = bus.destCommit % 32;
            e_rfdata = bus.result;
            e_pht = acc && bus.controlFlow[7] && bus.commitInfo[0];
            e_btb = acc && bus.controlFlow[7] && bus.controlFlow[4];
            e_pidx = bus.previousIndex;
            e_pst = (bus.controlFlow >> 5) & 3;
            e_bpc = bus.oldPC;
            e_btgt = bus.targetAddress;
            e_redir = det;
            e_rpc = bus.controlFlow[3] ? bus.targetAddress : bus.oldPC + 32'd4;
            e_snap = bus.statusSnap;
            if (memAck && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (acc && bus.commitInfo[2]) begin
                if (q_addr.size() < SQ) begin
                    q_addr.push_back(bus.destCommit);
                    q_data.push_back(bus.result);
                end else begin
                    tests_run++; tests_failed++;
                    $display("FAIL store_overflow: store to %h with queue full", bus.destCommit);
                end
            end
            if (acc) m_ret++;
            if (det) m_fl++;
            if (det) flush_left = FC;
            else if (flush_left > 0) flush_left--;
            e_flush = flush_left > 0;
            e_freeze = e_flush || (q_addr.size() >= SQ - 1);
        end
    end

    always @(negedge clk) begin : compare
        check("rfWrite", 32'(rfWrite), 32'(e_rfw));
        check("redirect", 32'(redirect), 32'(e_redir));
        check("statusRestore", 32'(statusRestore), 32'(e_redir));
        check("phtUpdate", 32'(phtUpdate), 32'(e_pht));
        check("btbWrite", 32'(btbWrite), 32'(e_btb));
        check("flush", 32'(flush), 32'(e_flush));
        check("freeze", 32'(freeze), 32'(e_freeze));
        check("memReq", 32'(memReq), 32'(q_addr.size() > 0));
        if (e_rfw) begin
            check("rfDest", 32'(rfDest), e_rfdest);
            check("rfData", rfData, e_rfdata);
        end
        if (e_redir) begin
            check("redirectPC", redirectPC, e_rpc);
            check("statusSnapOut", statusSnapOut, e_snap);
        end
        if (e_pht) begin
            check("phtIndex", 32'(phtIndex), e_pidx);
            check("phtState", 32'(phtState), e_pst);
        end
        if (e_btb) begin
            check("btbPC", btbPC, e_bpc);
            check("btbTarget", btbTarget, e_btgt);
        end
        if (q_addr.size() > 0) begin
            check("memAddr", memAddr, q_addr[0]);
            check("memData", memData, q_data[0]);
        end
`ifdef COMMIT_STATS_EN
        check("retiredCount", retiredCount, m_ret);
        check("flushCount", flushCount, m_fl);
        check("stallCycles", stallCycles, m_stall);
`endif
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] ci, input logic [7:0] cf,
                         input logic [31:0] dest, input logic [31:0] res, input logic [31:0] tgt,
                         input logic [31:0] pc, input logic [31:0] snap, input logic [7:0] idx);
        bus.validCommit = v;   bus.commitInfo = ci;     bus.controlFlow = cf;
        bus.destCommit = dest; bus.result = res;        bus.targetAddress = tgt;
        bus.oldPC = pc;        bus.statusSnap = snap;   bus.previousIndex = idx;
    endtask

    task automatic idle();
        bus = '0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_rfWrite", 32'(rfWrite), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_freeze", 32'(freeze), 0);
        check("rst_memReq", 32'(memReq), 0);
        check("rst_redirect", 32'(redirect), 0);
        resetN = 1'b1;
        tick();

        // Register write, then dest 0 suppressed
        drive(1, CI_RW, 0, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, 0); tick();
        check("t1_rfWrite", 32'(rfWrite), 1);
        check("t1_rfDest", 32'(rfDest), 5);
        check("t1_rfData", rfData, 32'hDEAD_BEEF);
        drive(1, CI_RW, 0, 32'd0, 32'h1234, 0, 0, 0, 0); tick();
        check("t1_dest0", 32'(rfWrite), 0);
        idle(); tick();

        // Three stores with memAck low, then in-order drain
        for (int i = 0; i < 3; i++) begin
            drive(1, CI_MW, 0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0, 0, 0); tick();
        end
        idle();
        check("t2_freeze3", 32'(freeze), 1);
        check("t2_addr_head", memAddr, 32'h100);
        tick(); tick();
        check("t2_addr_held", memAddr, 32'h100);
        check("t2_memReq_held", 32'(memReq), 1);
        memAck = 1'b1; tick();
        check("t2_addr2", memAddr, 32'h104);
        check("t2_freeze_off", 32'(freeze), 0);
        tick();
        check("t2_addr3", memAddr, 32'h108);
        check("t2_data3", memData, 32'hA2);
        tick();
        check("t2_empty", 32'(memReq), 0);
        memAck = 1'b0;

        // Fill FIFO, then enqueue and pop on the same edge while full
        for (int i = 0; i < 4; i++) begin
            drive(1, CI_MW, 0, 32'h400 + 32'(4 * i), 32'hB0 + 32'(i), 0, 0, 0, 0); tick();
        end
        drive(1, CI_MW, 0, 32'h410, 32'hB4, 0, 0, 0, 0); memAck = 1'b1; tick();
        idle();
        check("t2b_freeze_full", 32'(freeze), 1);
        check("t2b_head", memAddr, 32'h404);
        repeat (4) tick();
        check("t2b_drained", 32'(memReq), 0);
        memAck = 1'b0;

        // Taken-branch mispredict
        drive(1, CI_BR, CF_CTRL | CF_MISP | CF_TAKEN | CF_BTB | 8'h40, 0, 0, 32'h200, 32'h1000, 32'h5A5A, 8'h3C);
        tick();
        check("t3_redirect", 32'(redirect), 1);
        check("t3_redirectPC", redirectPC, 32'h200);
        check("t3_restore", 32'(statusRestore), 1);
        check("t3_snap", statusSnapOut, 32'h5A5A);
        check("t3_phtState", 32'(phtState), 2);
        check("t3_phtIndex", 32'(phtIndex), 32'h3C);
        check("t3_btbPC", btbPC, 32'h1000);
        check("t3_flush1", 32'(flush), 1);
        drive(1, CI_RW, 0, 32'd7, 32'h77, 0, 0, 0, 0); tick();
        check("t3_flush2", 32'(flush), 1);
        check("t3_redirect_off", 32'(redirect), 0);
        check("t3_squash1", 32'(rfWrite), 0);
        tick();
        check("t3_flush_end", 32'(flush), 0);
        check("t3_squash2", 32'(rfWrite), 0);
        tick();
        check("t3_resume", 32'(rfWrite), 1);
        check("t3_resume_dest", 32'(rfDest), 7);
        idle(); tick();

        // Not-taken misdirect at top of address space wraps
        drive(1, 4'h0, CF_CTRL | CF_MISD, 0, 0, 32'h500, 32'hFFFF_FFFC, 32'h1, 0); tick();
        check("t4_redirect", 32'(redirect), 1);
        check("t4_wrap", redirectPC, 32'h0000_0000);
        idle(); tick(); tick();
        check("t4_flush_end", 32'(flush), 0);

        // Older store keeps draining during flush
        drive(1, CI_MW, 0, 32'h300, 32'h11, 0, 0, 0, 0); tick();
        drive(1, CI_BR, CF_CTRL | CF_MISP, 0, 0, 32'h900, 32'h2000, 32'h2, 8'h01); tick();
        idle();
        check("t5_redirectPC", redirectPC, 32'h2004);
        check("t5_flush", 32'(flush), 1);
        check("t5_memReq", 32'(memReq), 1);
        check("t5_memAddr", memAddr, 32'h300);
        memAck = 1'b1; tick();
        check("t5_flush_drain", 32'(flush), 1);
        check("t5_drained", 32'(memReq), 0);
        memAck = 1'b0; tick(); tick();

        // Reset while flushing with a store pending
        drive(1, CI_MW, 0, 32'h600, 32'h22, 0, 0, 0, 0); tick();
        drive(1, CI_BR, CF_CTRL | CF_MISP, 0, 0, 32'h900, 32'h3000, 32'h3, 8'h02); tick();
        idle();
        check("t5b_pre_flush", 32'(flush), 1);
        check("t5b_pre_memReq", 32'(memReq), 1);
        #2 resetN = 1'b0;
        #1;
        check("t5b_flush", 32'(flush), 0);
        check("t5b_memReq", 32'(memReq), 0);
        check("t5b_freeze", 32'(freeze), 0);
        check("t5b_redirect", 32'(redirect), 0);
        tick();
        resetN = 1'b1;
        tick();

`ifdef COMMIT_STATS_EN
        for (int i = 0; i < 9; i++) begin
            drive(1, CI_RW, 0, 32'(i + 1), 32'(i), 0, 0, 0, 0); tick();
        end
        drive(1, CI_BR, CF_CTRL | CF_MISP, 0, 0, 32'h40, 32'h4000, 0, 0); tick();
        idle(); repeat (3) tick();
        check("t6_retired", retiredCount, 32'd10);
        check("t6_flushes", flushCount, 32'd1);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
